keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 180 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x4 keypad front end. Drives one column at a
// time, synchronises and samples the rows, forms a per-scan key candidate with
// ghost rejection, debounces it over whole scans and presents a stable one-hot
// {rows, cols} pair plus key_press / key_held status.
module keypad_scanner #(
   parameter int SCAN_DIV       = 16,
   parameter int DEBOUNCE_SCANS = 3,
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_drive,
   output logic [3:0] rows,
   output logic [3:0] cols,
   output logic       key_press,
   output logic       key_held
);

   localparam int DVW = $clog2(SCAN_DIV);
   localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DVW-1:0] DWELL_LAST = DVW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DEB_MAX    = DBW'(DEBOUNCE_SCANS);
   localparam logic [3:0]     ROW_IDLE   = ACTIVE_LOW ? 4'hF : 4'h0;

   typedef enum logic {S_IDLE, S_HELD} state_t;

   logic [3:0]          r_sync1, r_sync2;
   logic [3:0]          w_rows_hi;
   logic [DVW-1:0]      r_dwell;
   logic [1:0]          r_col;
   logic [2:0][3:0]     r_samp;        // rows seen in columns 0..2 this scan
   logic [3:0][3:0]     w_scan;        // full scan, column 3 taken live
   logic                w_dwell_end, w_eos, r_eos;
   logic [4:0]          w_nkeys;
   logic [3:0]          w_new_rows, w_new_cols;
   logic [3:0]          r_cand_rows, r_cand_cols;
   logic [DBW-1:0]      r_deb;
   state_t              r_state, w_state_nxt;
   logic                w_load, w_clear, w_press;
   logic [3:0]          w_col_onehot;

   // Column being driven, translated to pin polarity
   assign w_col_onehot = 4'b0001 << r_col;
   assign col_drive    = ACTIVE_LOW ? ~w_col_onehot : w_col_onehot;

   // Row pins cross into the clock domain; polarity normalised afterwards
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= ROW_IDLE;
         r_sync2 <= ROW_IDLE;
      end else begin
         r_sync1 <= row_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rows_hi   = ACTIVE_LOW ? ~r_sync2 : r_sync2;
   assign w_dwell_end = (r_dwell == DWELL_LAST);
   assign w_eos       = w_dwell_end && (r_col == 2'd3);

   // Dwell counter, column rotation and end-of-dwell row sampling
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dwell <= '0;
         r_col   <= 2'd0;
         r_samp  <= '0;
         r_eos   <= 1'b0;
      end else begin
         r_eos <= w_eos;
         if (w_dwell_end) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
            case (r_col)
               2'd0:    r_samp[0] <= w_rows_hi;
               2'd1:    r_samp[1] <= w_rows_hi;
               2'd2:    r_samp[2] <= w_rows_hi;
               default: ;
            endcase
         end else begin
            r_dwell <= r_dwell + DVW'(1);
         end
      end
   end

   assign w_scan = {w_rows_hi, r_samp};

   // Scan candidate: exactly one key across the whole scan, else none
   always_comb begin
      w_nkeys    = '0;
      w_new_rows = '0;
      w_new_cols = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (w_scan[c][r]) begin
               w_nkeys       = w_nkeys + 5'd1;
               w_new_rows[r] = 1'b1;
               w_new_cols[c] = 1'b1;
            end
         end
      end
      if (w_nkeys != 5'd1) begin
         w_new_rows = '0;
         w_new_cols = '0;
      end
   end

   // Debounce: count consecutive identical scan candidates, saturating
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cand_rows <= '0;
         r_cand_cols <= '0;
         r_deb       <= '0;
      end else if (w_eos) begin
         if ({w_new_rows, w_new_cols} == {r_cand_rows, r_cand_cols}) begin
            if (r_deb != DEB_MAX) r_deb <= r_deb + DBW'(1);
         end else begin
            r_deb <= DBW'(1);
         end
         r_cand_rows <= w_new_rows;
         r_cand_cols <= w_new_cols;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM decisions, taken the cycle after end of scan on a settled candidate
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_clear     = 1'b0;
      w_press     = 1'b0;
      if (r_eos && (r_deb == DEB_MAX)) begin
         case (r_state)
            S_IDLE: begin
               if (r_cand_cols != 4'd0) begin
                  w_state_nxt = S_HELD;
                  w_load      = 1'b1;
                  w_press     = 1'b1;
               end
            end
            S_HELD: begin
               if (r_cand_cols == 4'd0) begin
                  w_state_nxt = S_IDLE;
                  w_clear     = 1'b1;
               end else if ({r_cand_rows, r_cand_cols} != {rows, cols}) begin
                  w_load  = 1'b1;
                  w_press = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Output registers: rows/cols only move on FSM transitions
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rows      <= '0;
         cols      <= '0;
         key_press <= 1'b0;
      end else begin
         key_press <= w_press;
         if (w_load) begin
            rows <= r_cand_rows;
            cols <= r_cand_cols;
         end else if (w_clear) begin
            rows <= '0;
            cols <= '0;
         end
      end
   end

   assign key_held = (r_state == S_HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed tests with a resistive keypad model driving the
// active-low row pins from the pressed-key map and the driven column.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row_in;
   logic [3:0]  col_drive;
   logic [3:0]  rows, cols;
   logic        key_press, key_held;

   logic [15:0] keys;          // bit r*4+c = key at row r, column c closed
   logic [3:0]  act;
   int          n_chk, n_fail;
   int          n_press;
   logic        prev_press;
   logic        long_pulse;
   logic        mon_en, drop_seen;

   localparam logic [15:0] K1 = 16'h0001;   // row0/col0
   localparam logic [15:0] K5 = 16'h0020;   // row1/col1
   localparam logic [15:0] K9 = 16'h0400;   // row2/col2
   localparam logic [15:0] KD = 16'h8000;   // row3/col3

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .ACTIVE_LOW(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_drive (col_drive),
      .rows      (rows),
      .cols      (cols),
      .key_press (key_press),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a closed key pulls its row low while its column is driven low
   always_comb begin
      act = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_drive[c]) act[r] = 1'b1;
      row_in = ~act;
   end

   // Pulse counting, pulse width and held-drop monitors
   initial begin
      n_press = 0; prev_press = 1'b0; long_pulse = 1'b0; drop_seen = 1'b0;
   end
   always @(negedge clk) begin
      if (key_press === 1'b1) n_press++;
      if (key_press === 1'b1 && prev_press === 1'b1) long_pulse = 1'b1;
      prev_press = key_press;
      if (mon_en && key_held !== 1'b1) drop_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_press(input int max, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (key_press === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input int max, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (key_held === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic release_all(input string tag);
      logic ok;
      keys = '0;
      wait_idle(100, ok);
      chk({tag, "_idle"}, ok, 1'b1);
      repeat (20) @(negedge clk);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ok;
      int         p0;
      logic [3:0] prev_cd;
      n_chk = 0; n_fail = 0;
      keys = '0; mon_en = 1'b0;
      rst_n = 1'b0;

      // 1. reset state and column rotation
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_col_drive", col_drive, 4'b1110);
      chk("rst_rows", rows, 4'b0000);
      chk("rst_cols", cols, 4'b0000);
      chk("rst_press", key_press, 1'b0);
      chk("rst_held", key_held, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rot_k3", col_drive, 4'b1110);
      @(negedge clk);
      chk("rot_k4", col_drive, 4'b1101);
      repeat (4) @(negedge clk);
      chk("rot_k8", col_drive, 4'b1011);
      repeat (4) @(negedge clk);
      chk("rot_k12", col_drive, 4'b0111);
      repeat (4) @(negedge clk);
      chk("rot_k16", col_drive, 4'b1110);

      // 2. press and release '5'
      p0 = n_press;
      keys = K5;
      wait_press(68, ok);
      chk("k5_press_seen", ok, 1'b1);
      chk("k5_rows", rows, 4'b0010);
      chk("k5_cols", cols, 4'b0010);
      chk("k5_held", key_held, 1'b1);
      repeat (30) @(negedge clk);
      chk("k5_npress", n_press - p0, 1);
      keys = '0;
      repeat (20) @(negedge clk);
      chk("k5_held_early", key_held, 1'b1);
      wait_idle(80, ok);
      chk("k5_release", ok, 1'b1);
      chk("k5_rel_rows", rows, 4'b0000);
      chk("k5_rel_cols", cols, 4'b0000);
      repeat (10) @(negedge clk);
      chk("k5_rel_npress", n_press - p0, 1);

      // 3. bouncing '1' then closed
      repeat (20) @(negedge clk);
      p0 = n_press;
      for (int i = 0; i < 10; i++) begin
         keys = (i % 2 == 0) ? K1 : 16'h0;
         repeat (10) @(negedge clk);
      end
      keys = K1;
      repeat (120) @(negedge clk);
      chk("bounce_npress", n_press - p0, 1);
      chk("bounce_rows", rows, 4'b0001);
      chk("bounce_cols", cols, 4'b0001);
      chk("bounce_held", key_held, 1'b1);
      release_all("bounce");

      // 4. ghost: '1' and '5' together
      p0 = n_press;
      keys = K1 | K5;
      repeat (200) @(negedge clk);
      chk("ghost_npress", n_press - p0, 0);
      chk("ghost_rows", rows, 4'b0000);
      chk("ghost_cols", cols, 4'b0000);
      chk("ghost_held", key_held, 1'b0);
      release_all("ghost");

      // 5. roll from '1' to '9' without release
      p0 = n_press;
      keys = K1;
      wait_press(80, ok);
      chk("roll_first", ok, 1'b1);
      chk("roll_first_cols", cols, 4'b0001);
      drop_seen = 1'b0;
      mon_en = 1'b1;
      keys = K9;
      wait_press(100, ok);
      chk("roll_second", ok, 1'b1);
      chk("roll_rows", rows, 4'b0100);
      chk("roll_cols", cols, 4'b0100);
      repeat (10) @(negedge clk);
      mon_en = 1'b0;
      chk("roll_no_drop", drop_seen, 1'b0);
      chk("roll_npress", n_press - p0, 2);
      release_all("roll");

      // 6. reset in the middle of debouncing 'D'
      ok = 1'b0;
      prev_cd = col_drive;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (col_drive == 4'b1110 && prev_cd == 4'b0111) ok = 1'b1;
         prev_cd = col_drive;
      end
      chk("rst_align", ok, 1'b1);
      p0 = n_press;
      keys = KD;
      repeat (36) @(negedge clk);
      chk("rst_pre_npress", n_press - p0, 0);
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_rows", rows, 4'b0000);
      chk("rst_mid_cols", cols, 4'b0000);
      chk("rst_mid_held", key_held, 1'b0);
      chk("rst_mid_col_drive", col_drive, 4'b1110);
      chk("rst_mid_npress", n_press - p0, 0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("rst_fresh_npress", n_press - p0, 0);
      wait_press(40, ok);
      chk("rst_d_press", ok, 1'b1);
      chk("rst_d_rows", rows, 4'b1000);
      chk("rst_d_cols", cols, 4'b1000);
      chk("rst_d_held", key_held, 1'b1);
      release_all("rst_d");

      chk("pulse_width", long_pulse, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
